// File: rtl/instr_aligner.sv
// Realigns a stream of word-aligned fetch words into 16/32-bit RISC-V instructions,
// holding a leftover halfword when an instruction straddles two words.
module instr_aligner #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
   localparam int RISCV_WORD_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [RISCV_WORD_WIDTH-1:0] fetch_data_i,
   input  logic                        fetch_valid_i,
   output logic                        fetch_ready_o,
   input  logic                        branch_i,
   input  logic [RISCV_WORD_WIDTH-1:0] branch_addr_i,
   output logic [RISCV_WORD_WIDTH-1:0] instr_o,
   output logic [RISCV_WORD_WIDTH-1:0] instr_addr_o,
   output logic                        instr_valid_o,
   input  logic                        instr_ready_i
);

   typedef enum logic [1:0] {
      S_ALIGNED   = 2'd0,
      S_ODD_START = 2'd1,
      S_HALF      = 2'd2
   } state_t;

   localparam state_t RESET_STATE = BOOT_ADDR[1] ? S_ODD_START : S_ALIGNED;

   state_t                      state_r;
   logic [RISCV_WORD_WIDTH-1:0] pc_r;
   logic [15:0]                 hb_r;

   logic [RISCV_WORD_WIDTH-1:0] instr_s;
   logic                        valid_s;
   logic                        fready_s;
   logic                        kill_s;
   logic                        xfer_s;
   logic                        lo_comp_s;
   logic                        hi_comp_s;
   logic                        hb_comp_s;

   function automatic logic is_compressed(input logic [15:0] h);
      return (h[1:0] != 2'b11);
   endfunction

   assign lo_comp_s = is_compressed(fetch_data_i[15:0]);
   assign hi_comp_s = is_compressed(fetch_data_i[31:16]);
   assign hb_comp_s = is_compressed(hb_r);

   // Output selection and fetch consumption decoded from the current state.
   always_comb begin
      instr_s  = 32'h0000_0000;
      valid_s  = 1'b0;
      fready_s = 1'b0;
      case (state_r)
         S_ALIGNED: begin
            valid_s  = fetch_valid_i;
            fready_s = fetch_valid_i & instr_ready_i;
            if (lo_comp_s) begin
               instr_s = {16'h0000, fetch_data_i[15:0]};
            end else begin
               instr_s = fetch_data_i;
            end
         end
         S_ODD_START: begin
            if (hi_comp_s) begin
               valid_s  = fetch_valid_i;
               fready_s = fetch_valid_i & instr_ready_i;
               instr_s  = {16'h0000, fetch_data_i[31:16]};
            end else begin
               // Upper half starts a 32-bit instruction: swallow the word into hb.
               valid_s  = 1'b0;
               fready_s = 1'b1;
               instr_s  = 32'h0000_0000;
            end
         end
         S_HALF: begin
            if (hb_comp_s) begin
               valid_s  = 1'b1;
               fready_s = 1'b0;
               instr_s  = {16'h0000, hb_r};
            end else begin
               valid_s  = fetch_valid_i;
               fready_s = fetch_valid_i & instr_ready_i;
               instr_s  = {fetch_data_i[15:0], hb_r};
            end
         end
         default: begin
            instr_s  = 32'h0000_0000;
            valid_s  = 1'b0;
            fready_s = 1'b0;
         end
      endcase
   end

   assign kill_s        = branch_i | ~rst_n;
   assign instr_o       = instr_s;
   assign instr_addr_o  = pc_r;
   assign instr_valid_o = valid_s & ~kill_s;
   assign fetch_ready_o = fready_s & ~kill_s;
   assign xfer_s        = instr_valid_o & instr_ready_i;

   // PC, leftover halfword and alignment state; a redirect overrides everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= RESET_STATE;
         pc_r    <= BOOT_ADDR;
         hb_r    <= 16'h0000;
      end else if (branch_i) begin
         pc_r    <= branch_addr_i & 32'hFFFF_FFFE;
         hb_r    <= 16'h0000;
         state_r <= branch_addr_i[1] ? S_ODD_START : S_ALIGNED;
      end else begin
         case (state_r)
            S_ALIGNED: begin
               if (xfer_s && lo_comp_s) begin
                  hb_r    <= fetch_data_i[31:16];
                  pc_r    <= pc_r + 32'd2;
                  state_r <= S_HALF;
               end else if (xfer_s) begin
                  pc_r    <= pc_r + 32'd4;
               end else begin
                  pc_r    <= pc_r;
               end
            end
            S_ODD_START: begin
               if (hi_comp_s && xfer_s) begin
                  pc_r    <= pc_r + 32'd2;
                  state_r <= S_ALIGNED;
               end else if (!hi_comp_s && fetch_valid_i && fetch_ready_o) begin
                  hb_r    <= fetch_data_i[31:16];
                  state_r <= S_HALF;
               end else begin
                  pc_r    <= pc_r;
               end
            end
            S_HALF: begin
               if (hb_comp_s && xfer_s) begin
                  pc_r    <= pc_r + 32'd2;
                  state_r <= S_ALIGNED;
               end else if (!hb_comp_s && xfer_s) begin
                  hb_r    <= fetch_data_i[31:16];
                  pc_r    <= pc_r + 32'd4;
               end else begin
                  pc_r    <= pc_r;
               end
            end
            default: begin
               state_r <= RESET_STATE;
               pc_r    <= BOOT_ADDR;
               hb_r    <= 16'h0000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_aligner.sv
// Scoreboard bench for instr_aligner: words come from a fetch queue, expected
// instructions are queued as stimulus is built and compared on every output transfer.
module tb_instr_aligner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fetch_data_i;
   logic        fetch_valid_i;
   logic        fetch_ready_o;
   logic        branch_i;
   logic [31:0] branch_addr_i;
   logic [31:0] instr_o;
   logic [31:0] instr_addr_o;
   logic        instr_valid_o;
   logic        instr_ready_i;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] ad;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] word_q[$];
   logic        gap_mode = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;

   instr_aligner dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fetch_data_i  (fetch_data_i),
      .fetch_valid_i (fetch_valid_i),
      .fetch_ready_o (fetch_ready_o),
      .branch_i      (branch_i),
      .branch_addr_i (branch_addr_i),
      .instr_o       (instr_o),
      .instr_addr_o  (instr_addr_o),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i)
   );

   always #5 clk = ~clk;

   task automatic present();
      fetch_valid_i = (word_q.size() > 0) && (!gap_mode || ($urandom_range(0, 3) != 0));
      fetch_data_i  = (word_q.size() > 0) ? word_q[0] : 32'h0000_0000;
   endtask

   task automatic push_exp(input logic [31:0] ins, input logic [31:0] ad);
      exp_t e;
      e.ins = ins;
      e.ad  = ad;
      exp_q.push_back(e);
   endtask

   // Sample outputs at the falling edge, then advance one clock and update the fetch side.
   task automatic step(output logic v, output logic [31:0] ins, output logic [31:0] ad, output logic fr);
      @(negedge clk);
      v   = instr_valid_o;
      ins = instr_o;
      ad  = instr_addr_o;
      fr  = fetch_ready_o;
      @(posedge clk);
      #1;
      if (fr && fetch_valid_i) void'(word_q.pop_front());
      branch_i = 1'b0;
      present();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      branch_i = 1'b0;
      instr_ready_i = 1'b1;
      gap_mode = 1'b0;
      word_q.delete();
      exp_q.delete();
      present();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      branch_i = 1'b0;
      branch_addr_i = 32'h0;
      instr_ready_i = 1'b1;
      word_q.delete();
      word_q.push_back(32'h4585_4505);
      present();
      #2;
      vectors++;
      if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0 || instr_addr_o !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_state got v=%b fr=%b pc=%h want v=0 fr=0 pc=00000000", instr_valid_o, fetch_ready_o, instr_addr_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic v, fr;
      logic [31:0] ins, ad;
      exp_t e;
      push_exp(32'h0000_4505, 32'h0);
      push_exp(32'h0000_4585, 32'h2);
      for (int k = 0; k < 2; k++) begin
         step(v, ins, ad, fr);
         e = exp_q.pop_front();
         vectors++;
         if ({v, ins, ad, fr} !== {1'b1, e.ins, e.ad, (k == 0)}) begin
            miscompares++;
            $display("FAIL basic_%0d got v=%b %h@%h fr=%b want v=1 %h@%h fr=%b", k, v, ins, ad, fr, e.ins, e.ad, k == 0);
         end
      end
      step(v, ins, ad, fr);
      vectors++;
      if (v !== 1'b0 || ad !== 32'h4) begin
         miscompares++;
         $display("FAIL basic_idle got v=%b pc=%h want v=0 pc=00000004", v, ad);
      end
   endtask

   task automatic test_straddle();
      logic v, fr;
      logic [31:0] ins, ad;
      exp_t e;
      do_reset();
      word_q.push_back(32'h0513_4505);
      word_q.push_back(32'h4585_0000);
      present();
      push_exp(32'h0000_4505, 32'h0);
      push_exp(32'h0000_0513, 32'h2);
      push_exp(32'h0000_4585, 32'h6);
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         step(v, ins, ad, fr);
         if (v && instr_ready_i) begin
            e = exp_q.pop_front();
            vectors++;
            if (ins !== e.ins || ad !== e.ad) begin
               miscompares++;
               $display("FAIL straddle got %h@%h want %h@%h", ins, ad, e.ins, e.ad);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0 || word_q.size() != 0) begin
         miscompares++;
         $display("FAIL straddle_drain got %0d pending instr %0d words want 0 0", exp_q.size(), word_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_branch();
      logic v, fr;
      logic [31:0] ins, ad;
      exp_t e;
      // Odd target with compressed upper half, then confirm aligned follow-up.
      do_reset();
      word_q.push_back(32'h4505_1234);
      word_q.push_back(32'h0000_0513);
      present();
      branch_i = 1'b1;
      branch_addr_i = 32'h0000_0103;
      step(v, ins, ad, fr);
      vectors++;
      if (v !== 1'b0 || fr !== 1'b0) begin
         miscompares++;
         $display("FAIL branch_cycle got v=%b fr=%b want v=0 fr=0", v, fr);
      end
      push_exp(32'h0000_4505, 32'h102);
      push_exp(32'h0000_0513, 32'h104);
      // Odd target with a 32-bit instruction straddling into the next word.
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
         step(v, ins, ad, fr);
         if (v && instr_ready_i) begin
            e = exp_q.pop_front();
            vectors++;
            if (ins !== e.ins || ad !== e.ad) begin
               miscompares++;
               $display("FAIL branch_odd got %h@%h want %h@%h", ins, ad, e.ins, e.ad);
            end
         end
      end
      word_q.delete();
      word_q.push_back(32'h0513_1234);
      word_q.push_back(32'h0000_0000);
      present();
      branch_i = 1'b1;
      branch_addr_i = 32'h0000_0102;
      step(v, ins, ad, fr);
      step(v, ins, ad, fr);
      vectors++;
      if (v !== 1'b0 || fr !== 1'b1) begin
         miscompares++;
         $display("FAIL odd_swallow got v=%b fr=%b want v=0 fr=1", v, fr);
      end
      step(v, ins, ad, fr);
      vectors++;
      if ({v, ins, ad} !== {1'b1, 32'h0000_0513, 32'h0000_0102}) begin
         miscompares++;
         $display("FAIL odd_straddle got v=%b %h@%h want v=1 00000513@00000102", v, ins, ad);
      end
      // Back-to-back redirects: last one wins; all-zero halfword passes as compressed.
      word_q.delete();
      word_q.push_back(32'h0000_4505);
      present();
      branch_i = 1'b1;
      branch_addr_i = 32'h0000_0200;
      step(v, ins, ad, fr);
      branch_i = 1'b1;
      branch_addr_i = 32'h0000_0300;
      step(v, ins, ad, fr);
      push_exp(32'h0000_4505, 32'h300);
      push_exp(32'h0000_0000, 32'h302);
      // Wrap past the top of the address space.
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
         step(v, ins, ad, fr);
         if (v && instr_ready_i) begin
            e = exp_q.pop_front();
            vectors++;
            if (ins !== e.ins || ad !== e.ad) begin
               miscompares++;
               $display("FAIL branch_last got %h@%h want %h@%h", ins, ad, e.ins, e.ad);
            end
         end
      end
      word_q.delete();
      word_q.push_back(32'h4585_4505);
      word_q.push_back(32'h0000_0001);
      present();
      branch_i = 1'b1;
      branch_addr_i = 32'hFFFF_FFFC;
      step(v, ins, ad, fr);
      push_exp(32'h0000_4505, 32'hFFFF_FFFC);
      push_exp(32'h0000_4585, 32'hFFFF_FFFE);
      push_exp(32'h0000_0001, 32'h0000_0000);
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         step(v, ins, ad, fr);
         if (v && instr_ready_i) begin
            e = exp_q.pop_front();
            vectors++;
            if (ins !== e.ins || ad !== e.ad) begin
               miscompares++;
               $display("FAIL branch_wrap got %h@%h want %h@%h", ins, ad, e.ins, e.ad);
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL branch_drain got %0d pending want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_stall();
      logic v, fr;
      logic [31:0] ins, ad;
      do_reset();
      word_q.push_back(32'h0000_0513);
      instr_ready_i = 1'b0;
      present();
      for (int c = 0; c < 3; c++) begin
         step(v, ins, ad, fr);
         vectors++;
         if ({v, ins, ad, fr} !== {1'b1, 32'h0000_0513, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_%0d got v=%b %h@%h fr=%b want v=1 00000513@00000000 fr=0", c, v, ins, ad, fr);
         end
      end
      instr_ready_i = 1'b1;
      step(v, ins, ad, fr);
      vectors++;
      if ({v, ins, fr} !== {1'b1, 32'h0000_0513, 1'b1}) begin
         miscompares++;
         $display("FAIL stall_release got v=%b %h fr=%b want v=1 00000513 fr=1", v, ins, fr);
      end
      step(v, ins, ad, fr);
      vectors++;
      if (v !== 1'b0 || ad !== 32'h4) begin
         miscompares++;
         $display("FAIL stall_once got v=%b pc=%h want v=0 pc=00000004", v, ad);
      end
   endtask

   task automatic test_reset_mid();
      logic v, fr;
      logic [31:0] ins, ad;
      exp_t e;
      do_reset();
      word_q.push_back(32'h0513_4505);
      word_q.push_back(32'h4585_0000);
      present();
      step(v, ins, ad, fr);
      instr_ready_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0 || instr_addr_o !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_mid got v=%b fr=%b pc=%h want v=0 fr=0 pc=00000000", instr_valid_o, fetch_ready_o, instr_addr_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      instr_ready_i = 1'b1;
      word_q.delete();
      word_q.push_back(32'h4585_4505);
      present();
      push_exp(32'h0000_4505, 32'h0);
      push_exp(32'h0000_4585, 32'h2);
      for (int k = 0; k < 2; k++) begin
         step(v, ins, ad, fr);
         e = exp_q.pop_front();
         vectors++;
         if ({v, ins, ad} !== {1'b1, e.ins, e.ad}) begin
            miscompares++;
            $display("FAIL reset_restart_%0d got v=%b %h@%h want v=1 %h@%h", k, v, ins, ad, e.ins, e.ad);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic v, fr;
      logic [31:0] ins, ad, addr, base;
      logic [15:0] h, hi;
      logic [15:0] hw[$];
      exp_t e;
      for (int r = 0; r < 4; r++) begin
         do_reset();
         gap_mode = r[0];
         base = (r >= 2) ? 32'h0000_1002 : 32'h0000_1000;
         hw.delete();
         if (r >= 2) hw.push_back(16'($urandom));
         addr = base;
         for (int k = 0; k < 12; k++) begin
            h = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
               h[1:0] = 2'($urandom_range(0, 2));
               push_exp({16'h0000, h}, addr);
               hw.push_back(h);
               addr = addr + 32'd2;
            end else begin
               h[1:0] = 2'b11;
               hi = 16'($urandom);
               push_exp({hi, h}, addr);
               hw.push_back(h);
               hw.push_back(hi);
               addr = addr + 32'd4;
            end
         end
         if (hw.size() % 2 != 0) begin
            push_exp(32'h0000_0001, addr);
            hw.push_back(16'h0001);
         end
         for (int i = 0; i < hw.size(); i += 2) word_q.push_back({hw[i+1], hw[i]});
         branch_i = 1'b1;
         branch_addr_i = base;
         present();
         step(v, ins, ad, fr);
         for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
            instr_ready_i = ($urandom_range(0, 3) != 0);
            step(v, ins, ad, fr);
            if (v && instr_ready_i) begin
               e = exp_q.pop_front();
               vectors++;
               if (ins !== e.ins || ad !== e.ad) begin
                  miscompares++;
                  $display("FAIL stream_r%0d got %h@%h want %h@%h", r, ins, ad, e.ins, e.ad);
               end
            end
         end
         vectors++;
         if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stream_r%0d_timeout got %0d pending want 0", r, exp_q.size());
            exp_q.delete();
         end
         instr_ready_i = 1'b1;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_straddle();
      test_branch();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
